fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Upstream neighbour of the control unit in the multicycle MIPS datapath.
- Owns the PC and the instruction register (IR), and drives opcode/funct/shamt into the control unit.
- Takes back the control unit's branch/jump/memory/halt decisions, sequences the instruction and data memory requests, and commits the next PC.
- Produces the retire strobe that gates register-file writes.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, datapath word width

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
ihit  in  1  instruction memory read complete
imemload  in  32  instruction data from memory
imemREN  out  1  instruction read request
imemaddr  out  32  instruction address (equals PC)
dhit  in  1  data memory access complete
dread  in  1  from control unit: load instruction
dwrite  in  1  from control unit: store instruction
dmemREN  out  1  data read request
dmemWEN  out  1  data write request
BEQ  in  1  from control unit
BNE  in  1  from control unit
Jump  in  1  from control unit
JR  in  1  from control unit
halt  in  1  from control unit
zero  in  1  ALU zero flag
jr_target  in  32  register rs value for JR
opcode  out  6  IR[31:26], of type opcode_t
funct  out  6  IR[5:0], of type funct_t
shamt  out  5  IR[10:6]
imm16  out  16  IR[15:0]
pc  out  32  current PC
pc_plus4  out  32  pc + 4, for JAL link
retire  out  1  one-cycle strobe when the instruction commits; gates RegWr
halted  out  1  sticky halt indication
instr_count  out  32  retired-instruction counter

Behaviour:
- States: FETCH, EXEC, MEM, HALTED. The state type is fseq_state_t.
- Reset (RST high at a CLK edge, in any state, including during an outstanding request):
  - state=FETCH, pc=PC_RESET, IR=0, instr_count=0.
  - retire, halted, dmemREN and dmemWEN are 0.
  - imemREN=1 in the first cycle after reset.
  - Any pending ihit or dhit in the reset cycle is ignored.
- FETCH:
  - imemREN=1 and imemaddr=pc; held stable until ihit.
  - On ihit: IR<=imemload; go to EXEC.
  - dhit is ignored in this state.
- EXEC:
  - opcode/funct/shamt/imm16 decode combinationally from IR.
  - Control inputs are sampled in this cycle only.
  - If halt=1: go to HALTED. No retire, PC unchanged. halt takes priority over dread/dwrite.
  - Else if dread or dwrite: go to MEM.
  - Else: commit (see below) and go to FETCH.
- MEM:
  - dmemREN=dread and dmemWEN=dwrite, using the IR-decoded values, which stay stable because IR is held.
  - Both requests are held until dhit.
  - On dhit: commit and go to FETCH.
  - If dread and dwrite are both 1, dwrite wins and dmemREN=0.
- Commit (one cycle):
  - retire=1; pc<=next_pc; instr_count<=instr_count+1, wrapping 32'hFFFF_FFFF to 0.
- HALTED:
  - All requests are 0; halted=1; no further state change until reset.
- next_pc priority:
  1. JR: jr_target.
  2. Jump: {pc_plus4[31:28], IR[25:0], 2'b00}.
  3. (BEQ&zero)|(BNE&~zero): pc_plus4 + (sign-extended imm16 << 2), mod 2^32.
  4. Otherwise pc_plus4.
- Arithmetic: all PC arithmetic is unsigned 32-bit and wraps silently (pc=32'hFFFF_FFFC gives pc_plus4=0).
- Word alignment: pc[1:0] is always 00. jr_target[1:0] is forced to 00 on load.
- imemREN and dmemREN/dmemWEN are never asserted in the same cycle.

Decomposition:
- cpu_types_pkg gains:
  - fseq_state_t, a 2-bit enum: FETCH, EXEC, MEM, HALTED.
  - PC_INCR = 4.
- Existing opcode_t, funct_t, SHAM_W, IMM_W and ADDR_W are reused.
- One sub-module, next_pc_logic: purely combinational computation of next_pc and pc_plus4. The FSM, PC/IR registers and counter stay in fetch_sequencer.
- A fetch_sequencer_if interface with fs and tb modports mirrors the control unit interface style.

Test Plan:
1. Reset then ALU op:
   - Stimulus: RST 2 cycles; ihit after 3 wait cycles with imemload=addu encoding.
   - Required: imemREN high for 3 cycles; EXEC; retire pulse; pc 0 -> 4; instr_count=1.
2. Load with wait states:
   - Stimulus: dread=1 in EXEC; dhit after 4 cycles.
   - Required: dmemREN high exactly 4 cycles; imemREN 0 throughout; retire only on the dhit cycle; pc+=4.
3. Branches:
   - BEQ, zero=1, imm16=16'hFFFE at pc=0x20 -> pc=0x1C.
   - BNE with zero=1 -> pc=0x24.
4. Jump/JR priority:
   - Jump=1, JR=1, jr_target=0x103 -> pc=0x100.
   - Jump alone with IR[25:0]=26'h40 at pc=0x1000_0008 -> pc=0x1000_0100.
5. Halt:
   - Stimulus: halt=1 together with dwrite=1.
   - Required: no dmemWEN; halted=1 sticky for 20 cycles; no retire; ihit pulses ignored.
6. Reset mid-MEM:
   - Stimulus: RST asserted while dmemWEN=1 and dhit is pending.
   - Required: next cycle dmemWEN=0, pc=PC_RESET, state FETCH, instr_count=0.
   - Also cover: pc=0xFFFF_FFFC sequential retire wraps to 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// cpu_types_pkg: shared MIPS field widths, opcode/funct and fetch FSM types
// Rev 1.1
// ------------------------------------------------------------------------
package cpu_types_pkg;

    localparam int ADDR_W  = 26;
    localparam int IMM_W   = 16;
    localparam int SHAM_W  = 5;
    localparam int REG_W   = 5;
    localparam int PC_INCR = 4;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDIU = 6'h09,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B,
        OP_HALT  = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_JR   = 6'h08,
        FN_ADDU = 6'h21,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_SLT  = 6'h2A
    } funct_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } fseq_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// fetch_sequencer_if: bundle between fetch sequencer, memories and control
// Rev 1.0
// ------------------------------------------------------------------------
interface fetch_sequencer_if (input logic CLK);
    import cpu_types_pkg::*;

    logic                RST;
    logic                ihit;
    logic [31:0]         imemload;
    logic                imemREN;
    logic [31:0]         imemaddr;
    logic                dhit;
    logic                dread;
    logic                dwrite;
    logic                dmemREN;
    logic                dmemWEN;
    logic                BEQ;
    logic                BNE;
    logic                Jump;
    logic                JR;
    logic                halt;
    logic                zero;
    logic [31:0]         jr_target;
    opcode_t             opcode;
    funct_t              funct;
    logic [SHAM_W-1:0]   shamt;
    logic [IMM_W-1:0]    imm16;
    logic [31:0]         pc;
    logic [31:0]         pc_plus4;
    logic                retire;
    logic                halted;
    logic [31:0]         instr_count;

    modport fs (
        input  CLK, RST, ihit, imemload, dhit, dread, dwrite,
               BEQ, BNE, Jump, JR, halt, zero, jr_target,
        output imemREN, imemaddr, dmemREN, dmemWEN, opcode, funct, shamt,
               imm16, pc, pc_plus4, retire, halted, instr_count
    );

    modport tb (
        input  CLK, imemREN, imemaddr, dmemREN, dmemWEN, opcode, funct, shamt,
               imm16, pc, pc_plus4, retire, halted, instr_count,
        output RST, ihit, imemload, dhit, dread, dwrite,
               BEQ, BNE, Jump, JR, halt, zero, jr_target
    );

endinterface
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ------------------------------------------------------------------------
// next_pc_logic: combinational PC+4 and JR/Jump/branch target selection
// Rev 1.0
// ------------------------------------------------------------------------
module next_pc_logic
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic [WORD_W-1:0] pc_i,
    input  logic [WORD_W-1:0] jr_target_i,
    input  logic [IMM_W-1:0]  imm16_i,
    input  logic [ADDR_W-1:0] jaddr_i,
    input  logic              beq_i,
    input  logic              bne_i,
    input  logic              jump_i,
    input  logic              jr_i,
    input  logic              zero_i,
    output logic [WORD_W-1:0] next_pc_o,
    output logic [WORD_W-1:0] pc_plus4_o
);

    logic [WORD_W-1:0] w_br_offset;
    logic [WORD_W-1:0] w_br_target;
    logic              w_br_taken;

    assign pc_plus4_o  = pc_i + WORD_W'(PC_INCR);
    assign w_br_offset = {{(WORD_W-IMM_W-2){imm16_i[IMM_W-1]}}, imm16_i, 2'b00};
    assign w_br_target = pc_plus4_o + w_br_offset;
    assign w_br_taken  = (beq_i & zero_i) | (bne_i & ~zero_i);

    // Register targets are realigned so the PC never leaves a word boundary.
    always_comb begin
        next_pc_o = pc_plus4_o;
        if (jr_i) begin
            next_pc_o = jr_target_i & {{(WORD_W-2){1'b1}}, 2'b00};
        end else if (jump_i) begin
            next_pc_o = {pc_plus4_o[WORD_W-1:WORD_W-4], jaddr_i, 2'b00};
        end else if (w_br_taken) begin
            next_pc_o = w_br_target;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// fetch_sequencer: PC/IR owner, fetch-exec-mem sequencing and retire strobe
// Rev 1.0
// ------------------------------------------------------------------------
module fetch_sequencer
    import cpu_types_pkg::*;
#(
    parameter int                WORD_W   = 32,
    parameter logic [WORD_W-1:0] PC_RESET = '0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                ihit,
    input  logic [WORD_W-1:0]   imemload,
    output logic                imemREN,
    output logic [WORD_W-1:0]   imemaddr,
    input  logic                dhit,
    input  logic                dread,
    input  logic                dwrite,
    output logic                dmemREN,
    output logic                dmemWEN,
    input  logic                BEQ,
    input  logic                BNE,
    input  logic                Jump,
    input  logic                JR,
    input  logic                halt,
    input  logic                zero,
    input  logic [WORD_W-1:0]   jr_target,
    output opcode_t             opcode,
    output funct_t              funct,
    output logic [SHAM_W-1:0]   shamt,
    output logic [IMM_W-1:0]    imm16,
    output logic [WORD_W-1:0]   pc,
    output logic [WORD_W-1:0]   pc_plus4,
    output logic                retire,
    output logic                halted,
    output logic [31:0]         instr_count
);

    fseq_state_t       state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [31:0]       count_q, count_d;
    logic [WORD_W-1:0] w_next_pc;
    logic              w_commit;

    next_pc_logic #(.WORD_W(WORD_W)) u_next_pc (
        .pc_i        (pc_q),
        .jr_target_i (jr_target),
        .imm16_i     (ir_q[15:0]),
        .jaddr_i     (ir_q[25:0]),
        .beq_i       (BEQ),
        .bne_i       (BNE),
        .jump_i      (Jump),
        .jr_i        (JR),
        .zero_i      (zero),
        .next_pc_o   (w_next_pc),
        .pc_plus4_o  (pc_plus4)
    );

    // halt outranks a memory op so a halting instruction never touches dmem.
    always_comb begin
        state_d  = state_q;
        w_commit = 1'b0;
        case (state_q)
            FETCH: begin
                if (ihit) state_d = EXEC;
            end
            EXEC: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (dread | dwrite) begin
                    state_d = MEM;
                end else begin
                    w_commit = 1'b1;
                    state_d  = FETCH;
                end
            end
            MEM: begin
                if (dhit) begin
                    w_commit = 1'b1;
                    state_d  = FETCH;
                end
            end
            HALTED: state_d = HALTED;
            default: state_d = FETCH;
        endcase
    end

    assign ir_d    = ((state_q == FETCH) && ihit) ? imemload : ir_q;
    assign pc_d    = w_commit ? w_next_pc : pc_q;
    assign count_d = w_commit ? count_q + 32'd1 : count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            count_q <= count_d;
        end
    end

    assign imemREN     = (state_q == FETCH);
    assign imemaddr    = pc_q;
    assign dmemWEN     = (state_q == MEM) & dwrite;
    assign dmemREN     = (state_q == MEM) & dread & ~dwrite;
    assign retire      = w_commit & ~RST;
    assign halted      = (state_q == HALTED);
    assign pc          = pc_q;
    assign instr_count = count_q;

    assign opcode = opcode_t'(ir_q[31:26]);
    assign funct  = funct_t'(ir_q[5:0]);
    assign shamt  = ir_q[10:6];
    assign imm16  = ir_q[15:0];

endmodule
`default_nettype wire
